// File: rtl/dep_head_loader_pkg.sv
// Shared deparser types and constants, plus the head-loader additions
// (beat width, config base, seed record and FSM states).
package dep_head_loader_pkg;

    localparam int HEAD_WIDTH    = 512;
    localparam int TAG_WIDTH     = 3;
    localparam int TYPE_NUM      = 4;
    localparam int KEY_FILED_NUM = 4;
    localparam int OFFSET_WIDTH  = 8;
    localparam int SHIFT_WIDTH   = 16;
    localparam int INFO_W        = HEAD_WIDTH + TAG_WIDTH;

    typedef struct packed {
        logic [INFO_W-1:0]                            head;
        logic [INFO_W-1:0]                            meta;
        logic [TYPE_NUM-1:0][OFFSET_WIDTH-1:0]        type_offset;
        logic [KEY_FILED_NUM-1:0][OFFSET_WIDTH-1:0]   key_offset;
        logic [KEY_FILED_NUM-1:0]                     key_offset_v;
        logic [SHIFT_WIDTH-1:0]                       headShift;
        logic [SHIFT_WIDTH-1:0]                       metaShift;
        logic [SHIFT_WIDTH-1:0]                       total_metaShift;
        logic                                         metaShift_carry;
        logic [KEY_FILED_NUM-1:0][OFFSET_WIDTH-1:0]   key_replaceOffset;
        logic [KEY_FILED_NUM-1:0]                     key_replaceOffset_v;
        logic                                         key_replaceOffset_carry;
    } layer_info_t;

    localparam int         DATA_WIDTH    = 128;
    localparam int         HEAD_BEATS    = HEAD_WIDTH / DATA_WIDTH;
    localparam logic [3:0] CONF_BASE     = 4'hF;
    localparam int         KEY_ADDR_BASE = 8;
    localparam logic [3:0] SHIFT_ADDR    = 4'hF;

    typedef struct packed {
        logic [TYPE_NUM-1:0][OFFSET_WIDTH-1:0]        type_offset;
        logic [KEY_FILED_NUM-1:0][OFFSET_WIDTH-1:0]   key_offset;
        logic [KEY_FILED_NUM-1:0]                     key_offset_v;
        logic [SHIFT_WIDTH-1:0]                       headShift;
        logic [SHIFT_WIDTH-1:0]                       metaShift;
    } loader_seed_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_PAY   = 2'd3
    } loader_state_t;

    // Top bit of head slot idx; slot 0 carries the most significant header bits.
    function automatic int slot_hi(input int idx);
        return HEAD_WIDTH - 1 - idx * DATA_WIDTH;
    endfunction

endpackage

// File: rtl/dep_head_loader_if.sv
// Beat stream bundle (valid/ready/data/sop/eop) used for packet input and payload output.
interface dep_head_loader_if import dep_head_loader_pkg::*; #(
    parameter int W = DATA_WIDTH
) ();
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         sop;
    logic         eop;

    modport master (output valid, output data, output sop, output eop, input ready);
    modport slave  (input valid, input data, input sop, input eop, output ready);
endinterface

// File: rtl/dep_head_loader_skid.sv
// Two-entry skid buffer; in_ready depends only on registered occupancy,
// so full throughput is kept while the sink is ready.
module skid_buffer_2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic         push;
    logic         pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (srst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/dep_head_loader.sv
// Deparser entry stage: collects the packet head, issues one seeded layer record
// per packet and forwards the remaining beats through a skid buffer.
module dep_head_loader import dep_head_loader_pkg::*; (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_rule_wren,
    input  logic [31:0]              i_rule_addr,
    input  logic [31:0]              i_rule_wdata,
    dep_head_loader_if.slave         pkt_i,
    input  logic [INFO_W-1:0]        i_meta,
    output logic                     o_layer_valid,
    output layer_info_t              o_layer_info,
    dep_head_loader_if.master        pay_o,
    output logic [15:0]              o_err_cnt
);
    localparam int CNT_W = $clog2(HEAD_BEATS + 1);

    loader_state_t          state_q;
    logic [CNT_W-1:0]       beat_cnt_q;
    logic [HEAD_WIDTH-1:0]  head_q, head_d;
    logic [INFO_W-1:0]      meta_q, meta_d;
    loader_seed_t           seed_q, seed_d;
    logic [TAG_WIDTH-1:0]   pkt_id_q;
    logic [15:0]            err_cnt_q;
    logic                   layer_valid_q;
    layer_info_t            layer_info_q, rec_d;

    logic                   pkt_ready;
    logic                   accept;
    logic                   sop_start;
    logic                   head_fill;
    logic                   cnt_full;
    logic                   head_done;
    logic                   err_event;
    logic                   cfg_hit;
    logic [CNT_W-1:0]       fill_idx;
    logic [CNT_W-1:0]       beat_cnt_inc;
    logic                   skid_in_ready;
    logic                   unused_addr;

    assign unused_addr = ^i_rule_addr[27:4];

    always_comb begin
        pkt_ready = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_HEAD: pkt_ready = 1'b1;
            ST_PAY:           pkt_ready = skid_in_ready;
            default:          pkt_ready = 1'b0;
        endcase
    end
    assign pkt_i.ready = pkt_ready;

    assign accept       = pkt_i.valid && pkt_ready;
    assign sop_start    = (state_q == ST_IDLE) && accept && pkt_i.sop;
    assign head_fill    = sop_start || ((state_q == ST_HEAD) && accept);
    assign fill_idx     = sop_start ? '0 : beat_cnt_q;
    assign beat_cnt_inc = fill_idx + CNT_W'(1);
    assign cnt_full     = (beat_cnt_inc == CNT_W'(HEAD_BEATS));
    assign head_done    = head_fill && (pkt_i.eop || cnt_full);
    assign err_event    = ((state_q == ST_IDLE) && accept && !pkt_i.sop) ||
                          ((state_q == ST_HEAD || state_q == ST_PAY) && accept && pkt_i.sop);
    assign meta_d       = sop_start ? i_meta : meta_q;

    // A new sop clears every slot so a short packet leaves zeros behind its last beat.
    generate
        for (genvar gi = 0; gi < HEAD_BEATS; gi++) begin : g_slot
            localparam int HI = slot_hi(gi);
            assign head_d[HI -: DATA_WIDTH] =
                (head_fill && fill_idx == CNT_W'(gi)) ? pkt_i.data :
                sop_start                             ? '0 :
                                                        head_q[HI -: DATA_WIDTH];
        end
    endgenerate

    assign cfg_hit = i_rule_wren && (i_rule_addr[31:28] == CONF_BASE);

    always_comb begin
        seed_d = seed_q;
        if (cfg_hit) begin
            for (int i = 0; i < TYPE_NUM; i++) begin
                if (i_rule_addr[3:0] == 4'(i)) begin
                    seed_d.type_offset[i] = i_rule_wdata[OFFSET_WIDTH-1:0];
                end
            end
            for (int k = 0; k < KEY_FILED_NUM; k++) begin
                if (i_rule_addr[3:0] == 4'(KEY_ADDR_BASE + k)) begin
                    seed_d.key_offset[k]   = i_rule_wdata[OFFSET_WIDTH-1:0];
                    seed_d.key_offset_v[k] = i_rule_wdata[31];
                end
            end
            if (i_rule_addr[3:0] == SHIFT_ADDR) begin
                seed_d.headShift = i_rule_wdata[15:0];
                seed_d.metaShift = i_rule_wdata[31:16];
            end
        end
    end

    // Record uses the pre-write seed, so a same-cycle config write lands on the next packet.
    always_comb begin
        rec_d              = '0;
        rec_d.head         = {head_d, pkt_id_q};
        rec_d.meta         = meta_d;
        rec_d.type_offset  = seed_q.type_offset;
        rec_d.key_offset   = seed_q.key_offset;
        rec_d.key_offset_v = seed_q.key_offset_v;
        rec_d.headShift    = seed_q.headShift;
        rec_d.metaShift    = seed_q.metaShift;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_IDLE;
            beat_cnt_q    <= '0;
            head_q        <= '0;
            meta_q        <= '0;
            seed_q        <= '0;
            pkt_id_q      <= '0;
            err_cnt_q     <= '0;
            layer_valid_q <= 1'b0;
            layer_info_q  <= '0;
        end else begin
            head_q        <= head_d;
            meta_q        <= meta_d;
            seed_q        <= seed_d;
            layer_valid_q <= head_done;
            if (head_fill) begin
                beat_cnt_q <= beat_cnt_inc;
            end
            if (head_done) begin
                layer_info_q <= rec_d;
                pkt_id_q     <= pkt_id_q + TAG_WIDTH'(1);
            end
            if (err_event && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
            unique case (state_q)
                ST_IDLE, ST_HEAD: begin
                    if (head_fill) begin
                        if (pkt_i.eop)     state_q <= ST_ISSUE;
                        else if (cnt_full) state_q <= ST_PAY;
                        else               state_q <= ST_HEAD;
                    end
                end
                ST_PAY: begin
                    if (accept && pkt_i.eop) state_q <= ST_ISSUE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    skid_buffer_2 #(.W(DATA_WIDTH + 1)) u_skid (
        .clk       (i_clk),
        .srst      (i_rst),
        .in_valid  ((state_q == ST_PAY) && pkt_i.valid),
        .in_ready  (skid_in_ready),
        .in_data   ({pkt_i.eop, pkt_i.data}),
        .out_valid (pay_o.valid),
        .out_ready (pay_o.ready),
        .out_data  ({pay_o.eop, pay_o.data})
    );

    assign pay_o.sop     = 1'b0;
    assign o_layer_valid = layer_valid_q;
    assign o_layer_info  = layer_info_q;
    assign o_err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_dep_head_loader.sv
// Scoreboard bench for dep_head_loader: records and payload beats are predicted at send time.
module tb_dep_head_loader;
    import dep_head_loader_pkg::*;

    localparam int CW = INFO_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              wren;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic [CW-1:0]     meta;
    logic              layer_valid;
    layer_info_t       layer_info;
    logic [15:0]       err_cnt;

    dep_head_loader_if #(.W(DATA_WIDTH)) pkt ();
    dep_head_loader_if #(.W(DATA_WIDTH)) pay ();

    dep_head_loader dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rule_wren  (wren),
        .i_rule_addr  (addr),
        .i_rule_wdata (wdata),
        .pkt_i        (pkt.slave),
        .i_meta       (meta),
        .o_layer_valid(layer_valid),
        .o_layer_info (layer_info),
        .pay_o        (pay.master),
        .o_err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] head;
        logic [CW-1:0] meta;
        logic [7:0]    t0;
        logic [7:0]    k1;
        logic [3:0]    kv;
        logic [15:0]   hs;
        logic [15:0]   ms;
    } exp_rec_t;

    exp_rec_t              rec_q [$];
    int                    lat_q [$];
    logic [DATA_WIDTH:0]   pay_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_beats = 0;
    int n_pkts = 0;
    int n_pulses = 0;
    bit tx_done;

    logic [TAG_WIDTH-1:0] m_id;
    logic [7:0]  m_t0, m_k1;
    logic [3:0]  m_kv;
    logic [15:0] m_hs, m_ms;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] rand_meta();
        logic [575:0] t;
        for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
        return t[CW-1:0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rand_beat();
        logic [DATA_WIDTH-1:0] t;
        for (int i = 0; i < DATA_WIDTH / 32; i++) t[i*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic cfg_write(input logic [31:0] a, input logic [31:0] d);
        wren = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wren = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input logic [DATA_WIDTH-1:0] d, input logic sop, input logic eop,
                              input logic [CW-1:0] m, input bit note_lat, input bit cfg_here);
        int waited = 0;
        pkt.valid = 1'b1; pkt.data = d; pkt.sop = sop; pkt.eop = eop; meta = m;
        @(negedge clk);
        while (!pkt.ready && waited < 300) begin
            waited++;
            @(negedge clk);
        end
        if (!pkt.ready) begin
            check_val("beat_wait", CW'(waited), CW'(0));
        end else begin
            if (note_lat) lat_q.push_back(cyc);
            if (cfg_here) begin
                wren = 1'b1; addr = 32'hF000_0000; wdata = 32'd5;
            end
            acc_beats++;
        end
        @(posedge clk); #1;
        pkt.valid = 1'b0; wren = 1'b0;
    endtask

    task automatic send_packet(input int nb, input bit cfg_on_issue);
        logic [DATA_WIDTH-1:0] beats [$];
        logic [HEAD_WIDTH-1:0] h;
        logic [CW-1:0]         m;
        exp_rec_t              r;
        int                    nh;
        h  = '0;
        m  = rand_meta();
        nh = (nb < HEAD_BEATS) ? nb : HEAD_BEATS;
        for (int i = 0; i < nb; i++) beats.push_back(rand_beat());
        for (int i = 0; i < nh; i++) h[HEAD_WIDTH-1-i*DATA_WIDTH -: DATA_WIDTH] = beats[i];
        r.head = {h, m_id}; r.meta = m; r.t0 = m_t0; r.k1 = m_k1;
        r.kv = m_kv; r.hs = m_hs; r.ms = m_ms;
        rec_q.push_back(r);
        m_id++;
        n_pkts++;
        if (cfg_on_issue) m_t0 = 8'd5;
        for (int i = HEAD_BEATS; i < nb; i++) pay_q.push_back({(i == nb - 1), beats[i]});
        for (int i = 0; i < nb; i++)
            drive_beat(beats[i], (i == 0), (i == nb - 1), (i == 0) ? m : ~m,
                       (i == nh - 1), cfg_on_issue && (i == nh - 1));
    endtask

    task automatic model_reset();
        m_id = '0; m_t0 = '0; m_k1 = '0; m_kv = '0; m_hs = '0; m_ms = '0;
    endtask

    // Output monitor: layer records and payload beats are popped from the scoreboard.
    initial begin
        exp_rec_t r;
        forever begin
            @(negedge clk);
            if (!rst && layer_valid) begin
                n_pulses++;
                check_val("rec_avail", CW'(rec_q.size() != 0), CW'(1));
                if (rec_q.size() != 0) begin
                    r = rec_q.pop_front();
                    check_val("rec_head", layer_info.head, r.head);
                    check_val("rec_meta", layer_info.meta, r.meta);
                    check_val("rec_type0", CW'(layer_info.type_offset[0]), CW'(r.t0));
                    check_val("rec_key1", CW'(layer_info.key_offset[1]), CW'(r.k1));
                    check_val("rec_keyv", CW'(layer_info.key_offset_v), CW'(r.kv));
                    check_val("rec_shift", CW'({layer_info.headShift, layer_info.metaShift}),
                              CW'({r.hs, r.ms}));
                    check_val("rec_zero", CW'({layer_info.total_metaShift, layer_info.metaShift_carry,
                              layer_info.key_replaceOffset, layer_info.key_replaceOffset_v,
                              layer_info.key_replaceOffset_carry}), CW'(0));
                end
                check_val("lat_avail", CW'(lat_q.size() != 0), CW'(1));
                if (lat_q.size() != 0) check_val("rec_latency", CW'(cyc), CW'(lat_q.pop_front() + 1));
            end
            if (!rst && pay.valid && pay.ready) begin
                check_val("pay_avail", CW'(pay_q.size() != 0), CW'(1));
                if (pay_q.size() != 0) check_val("pay_beat", CW'({pay.eop, pay.data}), CW'(pay_q.pop_front()));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ready"}, CW'(pkt.ready), CW'(1));
        check_val({tag, "_lvalid"}, CW'(layer_valid), CW'(0));
        check_val({tag, "_linfo0"}, CW'(layer_info == '0), CW'(1));
        check_val({tag, "_pvalid"}, CW'(pay.valid), CW'(0));
        check_val({tag, "_pdata"}, CW'({pay.eop, pay.data}), CW'(0));
        check_val({tag, "_err"}, CW'(err_cnt), CW'(0));
    endtask

    initial begin
        int base;
        int waited;
        rst = 1'b1; wren = 1'b0; addr = '0; wdata = '0; meta = '0;
        pkt.valid = 1'b0; pkt.data = '0; pkt.sop = 1'b0; pkt.eop = 1'b0;
        pay.ready = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst0");
        @(posedge clk); #1;
        rst = 1'b0;

        cfg_write(32'hF000_0000, 32'd3);          m_t0 = 8'd3;
        cfg_write(32'hF000_0009, 32'h8000_0011);  m_k1 = 8'h11; m_kv = 4'b0010;
        cfg_write(32'hF000_000F, 32'h0020_0040);  m_hs = 16'h0040; m_ms = 16'h0020;

        send_packet(6, 1'b0);
        send_packet(2, 1'b0);

        // Sink stalls: two payload beats fill the skid, then input backpressure.
        pay.ready = 1'b0;
        base = acc_beats;
        tx_done = 1'b0;
        fork
            begin send_packet(10, 1'b0); tx_done = 1'b1; end
        join_none
        repeat (12) @(negedge clk);
        check_val("stall_ready", CW'(pkt.ready), CW'(0));
        check_val("stall_pvalid", CW'(pay.valid), CW'(1));
        check_val("stall_taken", CW'(acc_beats - base), CW'(HEAD_BEATS + 2));
        @(posedge clk); #1;
        pay.ready = 1'b1;
        waited = 0;
        while (!tx_done && waited < 500) begin
            @(posedge clk); #1;
            waited++;
        end
        check_val("stall_done", CW'(tx_done), CW'(1));
        repeat (4) @(posedge clk); #1;

        // Stray beat in IDLE, then reset in the middle of a head.
        drive_beat(rand_beat(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_val("err_idle", CW'(err_cnt), CW'(1));
        drive_beat(rand_beat(), 1'b1, 1'b0, rand_meta(), 1'b0, 1'b0);
        drive_beat(rand_beat(), 1'b0, 1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_state("rst_mid");
        @(posedge clk); #1;
        rst = 1'b0;
        drive_beat(rand_beat(), 1'b0, 1'b1, '0, 1'b0, 1'b0);
        check_val("err_after_rst", CW'(err_cnt), CW'(1));

        // 2^TAG_WIDTH+1 back-to-back packets: the last record wraps to pkt_id 0.
        for (int i = 0; i < (1 << TAG_WIDTH) + 1; i++) send_packet(1 + (i % 6), 1'b0);

        // Config write on the snapshot edge, then a write to a foreign base.
        send_packet(2, 1'b1);
        cfg_write(32'hE000_0000, 32'd9);
        send_packet(5, 1'b0);

        repeat (20) @(negedge clk);
        check_val("rec_q_empty", CW'(rec_q.size()), CW'(0));
        check_val("lat_q_empty", CW'(lat_q.size()), CW'(0));
        check_val("pay_q_empty", CW'(pay_q.size()), CW'(0));
        check_val("pulse_count", CW'(n_pulses), CW'(n_pkts));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dep_head_loader.md
# dep_head_loader

Entry stage of the deparser pipeline, directly upstream of the first deparser layer. It accepts a packet as a beat stream plus per-packet metadata and collects the first HEAD_WIDTH bits into a head register. It then issues one initial `layer_info_t` per packet, seeded from configured start offsets, and forwards the remaining payload beats on a separate stream through a 2-entry skid buffer.

## Interface
- DATA_WIDTH, 128: stream beat width; HEAD_WIDTH must be an integer multiple.
- HEAD_BEATS, HEAD_WIDTH/DATA_WIDTH: beats collected into the head.
- CONF_BASE, 4'hF: value of i_rule_addr[31:28] that selects this block.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_rule_wren  in  1  configuration write strobe.
- i_rule_addr  in  32  configuration address.
- i_rule_wdata  in  32  configuration write data.
- i_pkt_valid  in  1  input beat valid.
- o_pkt_ready  out  1  input beat accepted when high together with valid.
- i_pkt_data  in  DATA_WIDTH  beat; first beat holds the most significant header bits.
- i_pkt_sop  in  1  first beat of packet.
- i_pkt_eop  in  1  last beat of packet.
- i_meta  in  HEAD_WIDTH+TAG_WIDTH  packet metadata; sampled on the accepted sop beat.
- o_layer_valid  out  1  one-cycle pulse: o_layer_info is valid.
- o_layer_info  out  layer_info_t  initial layer record.
- o_pay_valid  out  1  payload beat valid.
- i_pay_ready  in  1  payload sink ready.
- o_pay_data  out  DATA_WIDTH  payload beat.
- o_pay_eop  out  1  last payload beat.

## Operation
- Config: a write with addr[31:28]==CONF_BASE updates the seed registers; all other addresses are ignored.
  - addr[3:0]<TYPE_NUM writes type_offset[addr[3:0]] from wdata LSBs.
  - addr[3:0]=8+k, k<KEY_FILED_NUM, writes key_offset[k] from wdata LSBs and key_offset_v[k] from wdata[31].
  - addr[3:0]=15 writes headShift from wdata[15:0] and metaShift from wdata[31:16].
- FSM states IDLE, HEAD, ISSUE, PAY.
  - IDLE: ready=1. An accepted sop beat writes head slot 0 and captures i_meta; beat_cnt:=1.
    - With eop on that beat: go to ISSUE.
    - Otherwise, HEAD_BEATS=1 goes to PAY, else HEAD.
    - A beat without sop in IDLE is dropped and counted in err_cnt (16 bit, saturating, debug).
  - HEAD: each accepted beat fills slot beat_cnt, then beat_cnt increments.
    - Eop goes to ISSUE.
    - beat_cnt reaching HEAD_BEATS goes to PAY.
    - Unfilled slots stay zero (head cleared on every sop).
  - PAY: beats go into the skid buffer; o_pkt_ready = !skid_full.
    - Accepted eop: set pay_eop and go to ISSUE.
    - A sop beat arriving in PAY or HEAD is treated as data (no resync) and counted in err_cnt.
  - ISSUE: o_pkt_ready=0 for one cycle; o_layer_valid=1; then IDLE.
- Entering PAY also pulses o_layer_valid in the same cycle, so each packet produces exactly one pulse.
- o_layer_info fields:
  - head = {collected bits, pkt_id}; pkt_id is a TAG_WIDTH counter incremented per issued record that wraps to 0.
  - meta = captured i_meta.
  - type_offset, key_offset, key_offset_v, headShift, metaShift come from the seed registers.
  - total_metaShift, metaShift_carry, key_replaceOffset, key_replaceOffset_v, key_replaceOffset_carry are all 0.
- The seed is snapshotted when the record is issued. A config write in the same cycle does not affect that record.

## Timing
- Reset values: o_pkt_ready=1, o_layer_valid=0, o_layer_info all zero, o_pay_valid=0, o_pay_data=0, o_pay_eop=0, seeds=0, pkt_id=0, err_cnt=0, state IDLE, skid buffer empty.
- Reset in mid-packet discards the partial head and the buffered payload. Beats that follow before the next sop are dropped and counted.
- Latency: o_layer_valid is asserted in the cycle after the last head beat is accepted (registered output). For a short packet it is asserted in the cycle after eop.
- There is no backpressure on o_layer_info; a downstream layer samples it on the pulse.
- Payload handshake: data holds stable while o_pay_valid && !i_pay_ready.
  - The 2-entry skid gives full throughput when i_pay_ready=1.
  - o_pkt_ready in PAY is registered (derived from buffer occupancy).
- Minimum packet spacing is 1 idle cycle (ISSUE or the PAY→IDLE transition).

## Structure
- Add to the shared deparser package: DATA_WIDTH, CONF_BASE, a `loader_seed_t` struct (the seed fields), and the state enum.
- `layer_info_t`, HEAD_WIDTH, TAG_WIDTH, TYPE_NUM, and KEY_FILED_NUM come from the existing package.
- Sub-module: `skid_buffer_2` (parameterized width, valid/ready both sides), reusable elsewhere.

## Test plan
- HEAD_BEATS=4, seeds type_offset[0]=3, key_offset_v[1]=1: send a 6-beat packet → one o_layer_valid 4 cycles after the first beat, head equal to beats 0–3, pkt_id=0, type_offset[0]=3, and 2 payload beats with eop on the second.
- 2-beat packet with eop → head = beats 0,1 then 2×DATA_WIDTH zero bits; pulse the cycle after eop; no payload beats.
- i_pay_ready held 0 for 5 cycles during payload → o_pkt_ready falls after 2 buffered beats; no beat lost or duplicated; order preserved.
- Back-to-back 2^TAG_WIDTH+1 packets → pkt_id wraps to 0 on the last record; exactly one pulse per packet.
- Non-sop beat in IDLE, then reset asserted mid-head → err_cnt=1; outputs return to reset values; the next clean packet yields pkt_id=0.
- Config write to addr {CONF_BASE,…,4'h0}, wdata=5, in the issue cycle → current record keeps the old value; the next record has type_offset[0]=5. A write with a different addr[31:28] has no effect.
